// File: rtl/vga_pkg.sv
// Shared 640x480@60 raster constants and FSM state type, used by the timing
// generator and by the pixel fetcher so screen geometry has a single source.
package vga_pkg;

  localparam int CNT_W  = 10;
  localparam int FCNT_W = 16;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FRONT  = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BACK   = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FRONT  = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BACK   = 33;

  function automatic int seg_total(input int active, input int front,
                                   input int sync, input int back);
    return active + front + sync + back;
  endfunction

  localparam int VGA_H_TOTAL = seg_total(VGA_H_ACTIVE, VGA_H_FRONT, VGA_H_SYNC, VGA_H_BACK);
  localparam int VGA_V_TOTAL = seg_total(VGA_V_ACTIVE, VGA_V_FRONT, VGA_V_SYNC, VGA_V_BACK);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } vga_state_t;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster bundle between the timing generator (master), the pixel fetcher and
// the ADV7123 DAC pins; the consumer side owns the run request.
interface vga_timing_gen_if;
  import vga_pkg::*;

  logic              enable;
  logic [CNT_W-1:0]  h_counter;
  logic [CNT_W-1:0]  v_counter;
  logic              video_on;
  logic              line_start;
  logic              frame_start;
  logic [FCNT_W-1:0] frame_count;
  logic              VGA_HS;
  logic              VGA_VS;
  logic              VGA_BLANK_N;
  logic              VGA_SYNC_N;
  logic              VGA_CLK;

  modport master (
    input  enable,
    output h_counter, v_counter, video_on, line_start, frame_start, frame_count,
    output VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK
  );

  modport slave (
    output enable,
    input  h_counter, v_counter, video_on, line_start, frame_start, frame_count,
    input  VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK
  );

endinterface

// File: rtl/sync_delay_line.sv
// N-stage clocked shift register with a per-bit reset value; DEPTH = 0 is a
// plain wire so the caller can dial the alignment down to nothing.
module sync_delay_line #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  if (DEPTH == 0) begin : g_bypass
    assign o_q = i_d;
  end else begin : g_pipe
    logic [WIDTH-1:0] r_dly_p [DEPTH];

    // stage 0 takes the input, stage k takes stage k-1
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) begin
          r_dly_p[i] <= RST_VAL;
        end
      end else begin
        r_dly_p[0] <= i_d;
        for (int i = 1; i < DEPTH; i++) begin
          r_dly_p[i] <= r_dly_p[i-1];
        end
      end
    end

    assign o_q = r_dly_p[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate h/v counters for the fetcher, plus
// DAC sync/blank pins delayed to line up with the fetcher's registered RGB.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = VGA_H_ACTIVE,
  parameter int H_FRONT    = VGA_H_FRONT,
  parameter int H_SYNC     = VGA_H_SYNC,
  parameter int H_BACK     = VGA_H_BACK,
  parameter int V_ACTIVE   = VGA_V_ACTIVE,
  parameter int V_FRONT    = VGA_V_FRONT,
  parameter int V_SYNC     = VGA_V_SYNC,
  parameter int V_BACK     = VGA_V_BACK,
  parameter int CLK_DIV    = 2,
  parameter int SYNC_DELAY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  vga_timing_gen_if.master bus
);

  localparam int H_TOTAL = seg_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = seg_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);
  localparam int DIV_W   = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FRONT);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FRONT);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC);

  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("vga_timing_gen: CLK_DIV must be at least 2");
  end
  if (SYNC_DELAY < 0 || SYNC_DELAY > 4) begin : g_bad_sync_delay
    $error("vga_timing_gen: SYNC_DELAY must be within 0..4");
  end
  if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_bad_totals
    $error("vga_timing_gen: raster totals exceed counter width");
  end

  logic [DIV_W-1:0]  r_div;
  logic [DIV_W-1:0]  w_div_nxt;
  logic              w_pix_en;
  logic              r_vga_clk;

  vga_state_t        r_state;
  vga_state_t        w_state_nxt;

  logic [CNT_W-1:0]  r_h;
  logic [CNT_W-1:0]  r_v;
  logic [CNT_W-1:0]  w_h_nxt;
  logic [CNT_W-1:0]  w_v_nxt;
  logic              w_h_wrap;
  logic              w_frame_wrap;

  logic              w_line_start_nxt;
  logic              w_frame_start_nxt;
  logic              w_frame_inc;
  logic              r_line_start;
  logic              r_frame_start;
  logic [FCNT_W-1:0] r_frame_count;

  logic              w_active_nxt;
  logic              w_video_on_nxt;
  logic              w_hsync_nxt;
  logic              w_vsync_nxt;
  logic              r_video_on_p0;
  logic              r_hsync_p0;
  logic              r_vsync_p0;
  logic [2:0]        w_dly_out;

  // Free-running divider; the DAC clock is high in the second half of each period.
  assign w_pix_en  = (r_div == DIV_LAST);
  assign w_div_nxt = w_pix_en ? '0 : r_div + DIV_W'(1);

  assign w_h_wrap     = (r_h == H_LAST);
  assign w_frame_wrap = w_h_wrap && (r_v == V_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_h_nxt           = r_h;
    w_v_nxt           = r_v;
    w_line_start_nxt  = 1'b0;
    w_frame_start_nxt = 1'b0;
    w_frame_inc       = 1'b0;

    case (r_state)
      IDLE: begin
        w_h_nxt = '0;
        w_v_nxt = '0;
        if (w_pix_en && bus.enable) begin
          w_state_nxt       = RUN;
          w_frame_start_nxt = 1'b1;
        end
      end

      // RUN and DRAIN only differ in whether the raster continues past the wrap
      RUN, DRAIN: begin
        w_state_nxt = bus.enable ? RUN : DRAIN;
        if (w_pix_en) begin
          if (w_h_wrap) begin
            w_h_nxt          = '0;
            w_v_nxt          = (r_v == V_LAST) ? '0 : r_v + CNT_W'(1);
            w_line_start_nxt = 1'b1;
          end else begin
            w_h_nxt = r_h + CNT_W'(1);
          end

          if (w_frame_wrap) begin
            w_frame_inc = 1'b1;
            if (bus.enable) begin
              w_frame_start_nxt = 1'b1;
            end else begin
              w_state_nxt      = IDLE;
              w_line_start_nxt = 1'b0;
            end
          end
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_h_nxt     = '0;
        w_v_nxt     = '0;
      end
    endcase
  end

  // Decode from the next counter values so the raw sync/blank bits line up with h/v.
  assign w_active_nxt   = (w_state_nxt != IDLE);
  assign w_video_on_nxt = w_active_nxt && (w_h_nxt < H_VIS) && (w_v_nxt < V_VIS);
  assign w_hsync_nxt    = !(w_active_nxt && (w_h_nxt >= HS_BEG) && (w_h_nxt < HS_END));
  assign w_vsync_nxt    = !(w_active_nxt && (w_v_nxt >= VS_BEG) && (w_v_nxt < VS_END));

  // stage p0: counters, pulses and raw decode, all aligned to each other
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div         <= '0;
      r_vga_clk     <= 1'b0;
      r_h           <= '0;
      r_v           <= '0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_count <= '0;
      r_video_on_p0 <= 1'b0;
      r_hsync_p0    <= 1'b1;
      r_vsync_p0    <= 1'b1;
    end else begin
      r_div         <= w_div_nxt;
      r_vga_clk     <= (w_div_nxt >= DIV_HALF);
      r_h           <= w_h_nxt;
      r_v           <= w_v_nxt;
      r_line_start  <= w_line_start_nxt;
      r_frame_start <= w_frame_start_nxt;
      if (w_frame_inc) begin
        r_frame_count <= r_frame_count + FCNT_W'(1);
      end
      r_video_on_p0 <= w_video_on_nxt;
      r_hsync_p0    <= w_hsync_nxt;
      r_vsync_p0    <= w_vsync_nxt;
    end
  end

  // stage p1..pN: DAC-side alignment with the fetcher's registered RGB
  sync_delay_line #(
    .WIDTH   (3),
    .DEPTH   (SYNC_DELAY),
    .RST_VAL (3'b110)
  ) u_sync_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   ({r_hsync_p0, r_vsync_p0, r_video_on_p0}),
    .o_q   (w_dly_out)
  );

  assign bus.h_counter   = r_h;
  assign bus.v_counter   = r_v;
  assign bus.video_on    = r_video_on_p0;
  assign bus.line_start  = r_line_start;
  assign bus.frame_start = r_frame_start;
  assign bus.frame_count = r_frame_count;
  assign bus.VGA_HS      = w_dly_out[2];
  assign bus.VGA_VS      = w_dly_out[1];
  assign bus.VGA_BLANK_N = w_dly_out[0];
  assign bus.VGA_SYNC_N  = 1'b0;
  assign bus.VGA_CLK     = r_vga_clk;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates 640x480@60 Hz VGA raster timing from the 50 MHz system clock.
- Drives h_counter, v_counter and video_on into the pixel fetcher directly downstream.
- Drives the sync, blank and clock pins to the ADV7123 DAC.
- Sync/blank outputs are delayed so they align with the fetcher's one-cycle registered RGB.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- CLK_DIV, 2, clk cycles per pixel; must be >= 2
- SYNC_DELAY, 1, clk cycles of delay on HS/VS/BLANK_N; allowed range 0..4

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  reset, asynchronous, active-low
- enable  in  1  raster run request; sampled at frame boundaries
- h_counter  out  10  current pixel column, 0..H_TOTAL-1
- v_counter  out  10  current line, 0..V_TOTAL-1
- video_on  out  1  high when h_counter < H_ACTIVE and v_counter < V_ACTIVE
- VGA_HS  out  1  horizontal sync, active-low, delayed
- VGA_VS  out  1  vertical sync, active-low, delayed
- VGA_BLANK_N  out  1  delayed copy of video_on
- VGA_SYNC_N  out  1  constant 0
- VGA_CLK  out  1  pixel clock to DAC, 50% duty, period CLK_DIV clk cycles
- line_start  out  1  one-clk pulse when h_counter wraps to 0
- frame_start  out  1  one-clk pulse when (h,v) becomes (0,0) in RUN
- frame_count  out  16  number of completed frames, wraps at 65535

Behaviour:
- Derived values: H_TOTAL = sum of the four H_* parameters (800); V_TOTAL = sum of the four V_* parameters (525).
- Reset (async, rst_n low) values:
  - state = IDLE
  - h_counter = 0, v_counter = 0, frame_count = 0
  - video_on = 0, VGA_BLANK_N = 0
  - VGA_HS = 1, VGA_VS = 1
  - VGA_CLK = 0
  - line_start = 0, frame_start = 0
  - all delay-line stages = inactive values (HS/VS = 1, BLANK_N = 0)
- Pixel enable:
  - Divider counts 0..CLK_DIV-1 continuously out of reset; pix_en is high when the divider = CLK_DIV-1.
  - VGA_CLK is high during the second half of each divider period.
- Counter advance (on pix_en, RUN/DRAIN only):
  - h increments; at H_TOTAL-1 it wraps to 0 and v increments.
  - v wraps to 0 at V_TOTAL-1 on the same pix_en as the h wrap.
  - Counters never leave range.
- Sync decode (registered from the counters):
  - hsync_raw = 0 when h is in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC), i.e. [656,752).
  - vsync_raw = 0 when v is in [V_ACTIVE+V_FRONT, +V_SYNC), i.e. [490,492).
- Delay line: hsync/vsync/video_on pass through a SYNC_DELAY-stage clk shift register to produce VGA_HS/VGA_VS/VGA_BLANK_N. h_counter, v_counter and video_on themselves are undelayed.
- FSM states IDLE, RUN, DRAIN:
  - IDLE: counters held at 0; video_on = 0; no pulses. enable = 1 -> RUN on the next pix_en.
  - RUN: counters advance. At the frame wrap ((h,v) = (H_TOTAL-1, V_TOTAL-1) with pix_en):
    - frame_count increments.
    - If enable = 1: frame_start pulses and state stays RUN.
    - If enable = 0: -> IDLE.
  - RUN: enable dropping mid-frame -> DRAIN.
  - DRAIN: counters continue advancing. At the frame wrap -> IDLE and frame_count increments. If enable returns high during DRAIN -> RUN with no frame interruption.
- Pulse rules:
  - line_start is coincident with the clk where h becomes 0 (RUN/DRAIN).
  - frame_start is also asserted on the IDLE->RUN transition cycle.
  - No pulse occurs in IDLE.
- A frame is never truncated except by reset. Reset mid-frame returns everything to reset values immediately; there is no partial-frame recovery.

Decomposition:
- Package vga_pkg holds:
  - typedef enum {IDLE, RUN, DRAIN} vga_state_t
  - default 640x480 timing localparams and H_TOTAL/V_TOTAL helper constants
  - these are shared with the pixel fetcher so its SCREEN_WIDTH/HEIGHT come from one place
- One sub-module, sync_delay_line: a parameterised N-stage shift register with reset value per bit. It is instantiated once, 3 bits wide.

Test Plan:
1. Reset then enable=1, run one full frame -> line_start every 1600 clk, frame_start period 840000 clk, frame_count = 1 after first wrap.
2. Sample at h=655/656/751/752 on v=0 -> VGA_HS (SYNC_DELAY=1 shift) reads 1/0/0/1; VGA_VS = 0 only on lines 490-491.
3. Check video_on at (639,479)=1, (640,479)=0, (0,480)=0 -> VGA_BLANK_N follows exactly 1 clk later.
4. Drop enable at v=100 -> frame completes to (799,524), state IDLE, counters stay 0, VGA_HS/VGA_VS = 1, frame_count +1, no further line_start.
5. Drop enable at v=100, reassert at v=300 -> no gap, frame_start pulses at the next wrap, counters continuous.
6. Assert rst_n low at (400,250) mid-line -> all outputs hit reset values asynchronously within the same cycle; release with enable=1 -> frame restarts from (0,0) with frame_start pulse.
